adc_conv_sequencer: RTL and testbench
=====================================

Name: adc_conv_sequencer

Overview:
- Sequences bursts of ADC conversions for the temperature path.
- A falling edge on trig_in starts a burst of 2^NAVG_LOG2 conversions. Each conversion is launched with an adc_start pulse and completed on the falling edge of adc_eoc.
- The samples are accumulated, and the truncated average is presented on a valid/ready output.
- All internal edge detectors are gated by the PLL locked flag.

Parameters:
DW, 12, ADC sample width
NAVG_LOG2, 2, log2 of the number of conversions averaged per burst
GAP, 4, idle cycles between one conversion's completion and the next adc_start (0 allowed)
TIMEOUT, 1023, maximum cycles spent in WAIT before a burst is aborted (must be ≥1)

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
locked  in  1  PLL lock; when low, the block freezes
trig_in  in  1  burst trigger; falling edge starts a burst; synchronous to clk
adc_eoc  in  1  ADC end-of-conversion; falling edge means adc_data is valid; synchronous to clk
adc_data  in  DW  ADC conversion result
adc_start  out  1  one-cycle conversion start pulse
res_data  out  DW  averaged result
res_valid  out  1  res_data valid
res_ready  in  1  consumer accepts res_data
busy  out  1  state != IDLE
timeout_err  out  1  sticky flag: last burst aborted by timeout

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (nrst). All state changes on the rising edge of clk.
- Reset values:
  - state = IDLE
  - adc_start = 0, res_valid = 0, res_data = 0, timeout_err = 0, busy = 0
  - accumulator, sample count, timer and edge registers = 0
- Edge detection (trig_in and adc_eoc):
  - Each input has a history flop that loads the input only while locked = 1 and holds otherwise.
  - fall = prev & ~cur, evaluated combinationally.
- locked = 0:
  - All state, counters and the accumulator hold.
  - adc_start is forced to 0.
  - res_valid and res_data hold.
  - No transitions occur.
- State machine (transitions only while locked = 1):
  - IDLE:
    - On trig_fall: clear accumulator, sample count and timeout_err; go to START.
    - A trigger seen at the same edge is the one accepted.
  - START:
    - adc_start = 1 for exactly this cycle.
    - Clear timer; go to WAIT next cycle.
  - WAIT:
    - Timer increments each cycle.
    - On adc_eoc_fall: add adc_data, zero-extended to DW+NAVG_LOG2 bits, to the accumulator, and increment the sample count.
      - If the count reaches 2^NAVG_LOG2, go to DONE.
      - Otherwise go to GAP, or directly to START if GAP = 0.
    - Else if timer = TIMEOUT-1 (TIMEOUT cycles elapsed): set timeout_err, discard the accumulator, go to IDLE. No result is produced.
    - If adc_eoc_fall and timeout occur in the same cycle, adc_eoc_fall wins.
  - GAP: count GAP cycles, then go to START.
  - DONE:
    - res_data = accumulator >> NAVG_LOG2 (truncate, no rounding). Registered on entry; res_valid = 1 from the first DONE cycle.
    - Hold res_valid and res_data until res_valid & res_ready, then go to IDLE next cycle with res_valid = 0.
- Latency:
  - trig_fall at edge N → adc_start high during cycle N+1.
  - Final adc_eoc_fall at edge M → res_valid high during cycle M+1.
- Ignored events:
  - trig_fall outside IDLE is ignored and not queued, including a trigger in the same cycle as the DONE handshake.
  - adc_eoc_fall outside WAIT is ignored.
- Accumulator: width DW+NAVG_LOG2; cannot overflow by construction.
- Reset mid-burst: immediate return to reset values; adc_start is never left high.

Test Plan:
- Basic average (DW=12, NAVG_LOG2=2, GAP=4): trig fall; answer each adc_start with an adc_eoc fall 10 cycles later, with adc_data 100, 101, 102, 105 → 4 adc_start pulses, each 1 cycle wide, spaced GAP+1 cycles after the preceding eoc edge; res_data = 102; res_valid 1 cycle after the 4th eoc edge.
- Truncation/max values: four samples of 4095 → res_data = 4095. Samples 0, 0, 0, 3 → res_data = 0.
- Backpressure: hold res_ready = 0 for 20 cycles → res_valid and res_data stable, busy = 1, an extra trig fall is ignored. After res_ready = 1 → IDLE next cycle, res_valid = 0.
- Timeout (TIMEOUT=16): never pulse adc_eoc → timeout_err = 1 exactly 16 cycles after entering WAIT; state IDLE; no res_valid. Next trig fall clears timeout_err. An eoc fall coinciding with the timeout cycle is accepted as a sample.
- Lock loss: drop locked for 50 cycles during WAIT, toggling adc_eoc meanwhile → timer and count frozen, adc_start = 0, no sample captured. After relock the burst completes normally with the correct average.
- Async reset: assert nrst low during the cycle adc_start = 1 → adc_start, busy and res_valid go low immediately, without waiting for a clock edge. After release, the block is in IDLE and waits for a new trig fall.

Source files
------------

// File: rtl/adc_conv_sequencer.sv
// ADC burst sequencer: launches 2^NAVG_LOG2 conversions per trigger fall
// and presents the truncated average on a valid/ready output.
module adc_conv_sequencer #(
  parameter int DW        = 12,
  parameter int NAVG_LOG2 = 2,
  parameter int GAP       = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          locked,
  input  logic          trig_in,
  input  logic          adc_eoc,
  input  logic [DW-1:0] adc_data,
  output logic          adc_start,
  output logic [DW-1:0] res_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          busy,
  output logic          timeout_err
);

  localparam int AW       = DW + NAVG_LOG2;
  localparam int CW       = NAVG_LOG2 + 1;
  localparam int TMAX     = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int TW       = $clog2(TMAX + 1);
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  localparam logic [CW-1:0] CNT_LAST = CW'((2 ** NAVG_LOG2) - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_END  = TW'(GAP_LAST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic            trig_q;
  logic            eoc_q;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [DW-1:0]   res_data_q, res_data_d;
  logic            res_valid_q, res_valid_d;
  logic            terr_q, terr_d;

  logic            trig_fall;
  logic            eoc_fall;
  logic [AW-1:0]   acc_sum;

  assign trig_fall = trig_q & ~trig_in;
  assign eoc_fall  = eoc_q & ~adc_eoc;
  assign acc_sum   = acc_q + {{NAVG_LOG2{1'b0}}, adc_data};

  assign adc_start   = locked && (state_q == S_START);
  assign busy        = (state_q != S_IDLE);
  assign res_data    = res_data_q;
  assign res_valid   = res_valid_q;
  assign timeout_err = terr_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      trig_q      <= 1'b0;
      eoc_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      // history only advances while the clock source is trusted
      if (locked) begin
        trig_q <= trig_in;
        eoc_q  <= adc_eoc;
      end
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      terr_q      <= terr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    terr_d      = terr_q;
    if (locked) begin
      unique case (state_q)
        S_IDLE: begin
          if (trig_fall) begin
            acc_d   = '0;
            cnt_d   = '0;
            terr_d  = 1'b0;
            state_d = S_START;
          end
        end
        S_START: begin
          tmr_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (eoc_fall) begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CW'(1);
            tmr_d = '0;
            if (cnt_q == CNT_LAST) begin
              res_data_d  = acc_sum[AW-1:NAVG_LOG2];
              res_valid_d = 1'b1;
              state_d     = S_DONE;
            end else begin
              state_d = (GAP == 0) ? S_START : S_GAP;
            end
          end else if (tmr_q == TMO_LAST) begin
            terr_d  = 1'b1;
            acc_d   = '0;
            state_d = S_IDLE;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        S_GAP: begin
          if (tmr_q == GAP_END) begin
            state_d = S_START;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Bench for adc_conv_sequencer: schedule-based reference model compared
// every cycle, plus directed bursts with hand-computed expectations.
module tb_adc_conv_sequencer;

  localparam int DW  = 12;
  localparam int NL  = 2;
  localparam int NS  = 4;
  localparam int GAP = 4;
  localparam int TO  = 16;

  logic          clk = 1'b0;
  logic          nrst;
  logic          locked;
  logic          trig_in;
  logic          adc_eoc;
  logic [DW-1:0] adc_data;
  logic          adc_start;
  logic [DW-1:0] res_data;
  logic          res_valid;
  logic          res_ready;
  logic          busy;
  logic          timeout_err;

  always #10 clk = ~clk;

  adc_conv_sequencer #(
    .DW(DW), .NAVG_LOG2(NL), .GAP(GAP), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .nrst(nrst), .locked(locked),
    .trig_in(trig_in), .adc_eoc(adc_eoc), .adc_data(adc_data),
    .adc_start(adc_start), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // reference model: time advances only on locked edges
  bit          m_tprev, m_eprev, m_burst, m_have, m_terr;
  logic [DW-1:0] m_res;
  int          m_samp[$];
  int          m_t, m_start;

  // stimulus state
  bit resp_en, rand_dly, toggle_en, rand_trig, rand_ready, rand_lock;
  int resp_cnt, resp_dly;
  int samp_q[$];
  int st_t[$];
  int eoc_t[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_tprev = 0; m_eprev = 0; m_burst = 0; m_have = 0; m_terr = 0;
    m_res = '0; m_samp.delete(); m_t = 0; m_start = 0;
  endtask

  task automatic model_edge();
    bit tf, ef;
    int s;
    if (!locked) return;
    tf = m_tprev && !trig_in;
    ef = m_eprev && !adc_eoc;
    m_tprev = trig_in;
    m_eprev = adc_eoc;
    if (!m_burst) begin
      if (tf) begin
        m_burst = 1; m_terr = 0; m_samp.delete();
        m_start = m_t + 1;
      end
    end else if (m_have) begin
      if (res_ready) begin m_have = 0; m_burst = 0; end
    end else if (m_t > m_start) begin
      if (ef) begin
        m_samp.push_back(int'(adc_data));
        if (m_samp.size() == NS) begin
          s = 0;
          foreach (m_samp[i]) s += m_samp[i];
          m_res = DW'(s / NS);
          m_have = 1;
        end else begin
          m_start = m_t + 1 + GAP;
        end
      end else if (m_t - m_start == TO) begin
        m_terr = 1; m_burst = 0;
      end
    end
    m_t++;
  endtask

  task automatic compare();
    chk("adc_start", adc_start,
        locked && m_burst && !m_have && (m_t == m_start));
    chk("res_valid", res_valid, m_have);
    chk("res_data", res_data, m_res);
    chk("busy", busy, m_burst);
    chk("timeout_err", timeout_err, m_terr);
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    if (nrst) model_edge();
    #2;
    cyc++;
    if (rand_lock) locked = ($urandom_range(0, 9) != 0);
    if (rand_trig) trig_in = ($urandom_range(0, 11) != 0);
    if (rand_ready) res_ready = ($urandom_range(0, 1) != 0);
    #1;
    adc_eoc = 1'b1;
    if (toggle_en) adc_eoc = ($urandom_range(0, 1) != 0);
    if (resp_cnt > 0 && locked) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        adc_eoc = 1'b0;
        if (samp_q.size() > 0) adc_data = DW'(samp_q.pop_front());
        else adc_data = DW'($urandom_range(0, 4095));
        eoc_t.push_back(cyc);
      end
    end
    if (resp_en && adc_start) begin
      resp_cnt = rand_dly ? $urandom_range(1, 18) : resp_dly;
      st_t.push_back(cyc);
    end
  endtask

  task automatic trig_fall(output int t0);
    trig_in = 1'b0;
    t0 = cyc;
    tick();
    trig_in = 1'b1;
  endtask

  task automatic wait_valid(input int bound, output int vc);
    int n = 0;
    while (!res_valid && n < bound) begin tick(); n++; end
    vc = cyc;
    if (!res_valid) begin
      n_checks++; n_errors++;
      $display("FAIL wait_valid no result within %0d cycles", bound);
    end
  endtask

  task automatic wait_start(input int bound, output int sc);
    int n = 0;
    while (!adc_start && n < bound) begin tick(); n++; end
    sc = cyc;
    if (!adc_start) begin
      n_checks++; n_errors++;
      $display("FAIL wait_start no adc_start within %0d cycles", bound);
    end
  endtask

  task automatic burst(input int a, input int b, input int c,
                       input int d, input int exp, input string nm);
    int t0, vc;
    samp_q = '{a, b, c, d};
    trig_fall(t0);
    wait_valid(400, vc);
    chk(nm, res_data, exp);
    repeat (3) tick();
  endtask

  initial begin
    int t0, vc, sc, n;
    nrst = 0; locked = 1; trig_in = 1; adc_eoc = 1; adc_data = '0;
    res_ready = 1;
    resp_en = 0; rand_dly = 0; toggle_en = 0;
    rand_trig = 0; rand_ready = 0; rand_lock = 0;
    resp_cnt = 0; resp_dly = 10;
    model_reset();
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_start", adc_start, 0);
    nrst = 1;
    repeat (3) tick();

    // basic average with timing
    resp_en = 1; resp_dly = 10;
    st_t.delete(); eoc_t.delete();
    samp_q = '{100, 101, 102, 105};
    trig_fall(t0);
    wait_valid(400, vc);
    chk("basic_avg", res_data, 102);
    chk("basic_nstart", st_t.size(), 4);
    if (st_t.size() == 4 && eoc_t.size() == 4) begin
      chk("basic_first_start", st_t[0] - t0, 1);
      for (int i = 1; i < 4; i++)
        chk("basic_spacing", st_t[i] - eoc_t[i-1], GAP + 1);
      chk("basic_valid_lat", vc - eoc_t[3], 1);
    end
    repeat (3) tick();

    burst(4095, 4095, 4095, 4095, 4095, "max_avg");
    burst(0, 0, 0, 3, 0, "trunc_avg");

    // backpressure with an ignored trigger
    res_ready = 0;
    samp_q = '{7, 8, 9, 10};
    trig_fall(t0);
    wait_valid(400, vc);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) trig_in = 1'b0;
      if (i == 6) trig_in = 1'b1;
      tick();
      chk("bp_valid", res_valid, 1);
      chk("bp_data", res_data, 8);
    end
    chk("bp_busy", busy, 1);
    res_ready = 1;
    tick();
    chk("bp_release_valid", res_valid, 0);
    chk("bp_release_busy", busy, 0);
    repeat (3) tick();
    chk("bp_trig_ignored", busy, 0);

    // timeout: no eoc at all
    resp_en = 0;
    trig_fall(t0);
    wait_start(10, sc);
    n = 0;
    while (!timeout_err && n < 40) begin tick(); n++; end
    chk("tmo_latency", cyc - sc - 1, TO);
    chk("tmo_busy", busy, 0);
    chk("tmo_valid", res_valid, 0);
    repeat (3) tick();
    resp_en = 1; resp_dly = 5;
    samp_q = '{11, 12, 13, 14};
    trig_fall(t0);
    chk("tmo_cleared", timeout_err, 0);
    wait_valid(400, vc);
    chk("tmo_next_avg", res_data, 12);
    repeat (3) tick();

    // eoc fall on the last timeout cycle is still a sample
    resp_dly = TO;
    burst(40, 50, 60, 70, 55, "tmo_edge_avg");
    chk("tmo_edge_err", timeout_err, 0);

    // lock loss during WAIT
    resp_dly = 12;
    samp_q = '{200, 300, 400, 500};
    trig_fall(t0);
    wait_start(10, sc);
    repeat (4) tick();
    locked = 0; toggle_en = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("lock_start", adc_start, 0);
    end
    toggle_en = 0;
    tick();
    locked = 1;
    wait_valid(400, vc);
    chk("lock_avg", res_data, 350);
    repeat (3) tick();

    // async reset while adc_start is high
    resp_dly = 5;
    trig_fall(t0);
    wait_start(10, sc);
    #1 nrst = 0;
    #1;
    chk("arst_start", adc_start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", res_valid, 0);
    model_reset();
    resp_cnt = 0;
    samp_q.delete();
    tick();
    nrst = 1;
    repeat (10) tick();
    chk("arst_idle", busy, 0);
    burst(1, 2, 3, 4, 2, "arst_after_avg");

    // randomized traffic
    rand_dly = 1; rand_trig = 1; rand_ready = 1; rand_lock = 1;
    repeat (3000) tick();
    rand_dly = 0; rand_trig = 0; rand_ready = 0; rand_lock = 0;
    resp_dly = 5; locked = 1; trig_in = 1; res_ready = 1;
    repeat (150) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
